// File: rtl/lw_feeder_pkg.sv
// Shared types, constants and helpers for the SHA/HMAC host feeder.
package lw_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_KEY,
    ST_MSG,
    ST_PAD,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WAIT
  } state_t;

  // Words per hash block (and key words per HMAC key block).
  localparam int unsigned BLK_WORDS = 16;
  // Widest supported core word; helpers operate at this width.
  localparam int unsigned MAX_W     = 64;
  // Padding marker byte, always placed in the first free byte slot.
  localparam logic [7:0]  PAD_MARK  = 8'h80;

  // Build the final padded word: keep the first nbytes bytes (MSB first),
  // place the marker right after them and zero everything below.
  // The word occupies the low bpw bytes of the MAX_W-wide vector.
  function automatic logic [MAX_W-1:0] merge_marker(input logic [MAX_W-1:0] data,
                                                    input int unsigned     nbytes,
                                                    input int unsigned     bpw);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_W / 8; i++) begin
      if (i < bpw) begin
        if (i < nbytes)       res[(bpw - 1 - i) * 8 +: 8] = data[(bpw - 1 - i) * 8 +: 8];
        else if (i == nbytes) res[(bpw - 1 - i) * 8 +: 8] = PAD_MARK;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lw_feeder_keyfile.sv
// 16-word HMAC key register file: one write port, one combinational read port.
module lw_feeder_keyfile
  import lw_feeder_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [BLK_WORDS];

  // Key storage; cleared only by reset, otherwise written on we.
  // NOTE: the key file is reset explicitly because a stale key must never leak into a new HMAC; that is why this is flops, not RAM.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < int'(BLK_WORDS); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lw_sha_host_feeder.sv
// Host-side feeder: streams optional HMAC key, message, padding and length
// to the lightweight SHA core and captures the resulting digest.
module lw_sha_host_feeder
  import lw_feeder_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int OPC_W  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 aresetn_i,
  input  logic                                 go_i,
  input  logic [OPC_W-1:0]                     opcode_i,
  input  logic                                 abort_i,
  input  logic                                 msg_valid_i,
  input  logic [WORD_W-1:0]                    msg_data_i,
  input  logic [$clog2(WORD_W/8):0]            msg_bytes_i,
  input  logic                                 msg_last_i,
  input  logic                                 msg_empty_i,
  output logic                                 msg_ready_o,
  input  logic                                 key_we_i,
  input  logic [3:0]                           key_addr_i,
  input  logic [WORD_W-1:0]                    key_wdata_i,
  output logic                                 core_start_o,
  output logic [OPC_W-1:0]                     core_opcode_o,
  output logic                                 core_abort_o,
  output logic [WORD_W-1:0]                    core_data_o,
  output logic                                 core_data_valid_o,
  output logic                                 core_last_o,
  input  logic                                 core_ready_i,
  output logic [WORD_W-1:0]                    core_key_o,
  output logic                                 core_key_valid_o,
  input  logic                                 core_key_ready_i,
  input  logic                                 core_done_i,
  input  logic [8*WORD_W-1:0]                  core_hash_i,
  output logic [8*WORD_W-1:0]                  hash_o,
  output logic                                 done_o,
  output logic                                 busy_o
);

  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;
  localparam int          CNT_W          = $clog2(WORD_W / 8) + 1;

  state_t           state, state_nxt;
  logic [OPC_W-1:0] opcode_q, opcode_nxt;
  logic             empty_q, empty_nxt;
  logic [63:0]      byte_cnt, byte_cnt_nxt;
  logic [3:0]       blk_idx, blk_nxt;
  logic [3:0]       key_idx, key_nxt;
  logic             mark_pending, mark_nxt;
  logic             done_nxt;
  logic             partial;
  logic [63:0]      bit_len;
  logic [WORD_W-1:0] key_word;

  lw_feeder_keyfile #(.WORD_W(WORD_W)) u_keyfile (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .we        (key_we_i && (state == ST_IDLE)),
    .waddr     (key_addr_i),
    .wdata     (key_wdata_i),
    .raddr     (key_idx),
    .rdata     (key_word)
  );

  assign partial       = (msg_bytes_i != CNT_W'(BYTES_PER_WORD));
  assign bit_len       = byte_cnt << 3;
  assign core_opcode_o = opcode_q;
  assign core_key_o    = core_key_valid_o ? key_word : '0;
  assign busy_o        = (state != ST_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state        <= ST_IDLE;
      opcode_q     <= '0;
      empty_q      <= 1'b0;
      byte_cnt     <= '0;
      blk_idx      <= '0;
      key_idx      <= '0;
      mark_pending <= 1'b0;
      done_o       <= 1'b0;
      hash_o       <= '0;
    end else begin
      state        <= state_nxt;
      opcode_q     <= opcode_nxt;
      empty_q      <= empty_nxt;
      byte_cnt     <= byte_cnt_nxt;
      blk_idx      <= blk_nxt;
      key_idx      <= key_nxt;
      mark_pending <= mark_nxt;
      done_o       <= done_nxt;
      if (done_nxt) hash_o <= core_hash_i;
    end
  end

  // Next-state and handshake outputs; abort overrides everything when busy.
  // NOTE: every output and *_nxt gets a default first so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt         = state;
    opcode_nxt        = opcode_q;
    empty_nxt         = empty_q;
    byte_cnt_nxt      = byte_cnt;
    blk_nxt           = blk_idx;
    key_nxt           = key_idx;
    mark_nxt          = mark_pending;
    done_nxt          = 1'b0;
    core_start_o      = 1'b0;
    core_abort_o      = 1'b0;
    core_data_o       = '0;
    core_data_valid_o = 1'b0;
    core_last_o       = 1'b0;
    core_key_valid_o  = 1'b0;
    msg_ready_o       = 1'b0;

    if (state != ST_IDLE && abort_i) begin
      core_abort_o = 1'b1;
      state_nxt    = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_i) begin
            opcode_nxt   = opcode_i;
            empty_nxt    = msg_empty_i;
            byte_cnt_nxt = '0;
            blk_nxt      = '0;
            key_nxt      = '0;
            mark_nxt     = msg_empty_i;
            state_nxt    = ST_START;
          end
        end
        ST_START: begin
          core_start_o      = 1'b1;
          core_data_valid_o = 1'b1;
          if (opcode_q[OPC_W-1]) state_nxt = ST_KEY;
          else                   state_nxt = empty_q ? ST_PAD : ST_MSG;
        end
        ST_KEY: begin
          core_key_valid_o = 1'b1;
          if (core_key_ready_i) begin
            key_nxt = key_idx + 4'd1;
            if (key_idx == 4'd15) begin
              byte_cnt_nxt = 64'(BLK_WORDS * BYTES_PER_WORD);
              state_nxt    = empty_q ? ST_PAD : ST_MSG;
            end
          end
        end
        ST_MSG: begin
          core_data_valid_o = msg_valid_i;
          msg_ready_o       = core_ready_i;
          if (msg_last_i && partial)
            core_data_o = WORD_W'(merge_marker(MAX_W'(msg_data_i), 32'(msg_bytes_i), BYTES_PER_WORD));
          else
            core_data_o = msg_data_i;
          if (msg_valid_i && core_ready_i) begin
            blk_nxt = blk_idx + 4'd1;
            if (msg_last_i) begin
              byte_cnt_nxt = byte_cnt + 64'(msg_bytes_i);
              mark_nxt     = !partial;
              state_nxt    = ST_PAD;
            end else begin
              byte_cnt_nxt = byte_cnt + 64'(BYTES_PER_WORD);
            end
          end
        end
        ST_PAD: begin
          if (!mark_pending && blk_idx == 4'd14) begin
            state_nxt = ST_LEN_HI;
          end else begin
            core_data_valid_o = 1'b1;
            core_data_o       = mark_pending ? {PAD_MARK, {(WORD_W-8){1'b0}}} : '0;
            if (core_ready_i) begin
              blk_nxt  = blk_idx + 4'd1;
              mark_nxt = 1'b0;
              if (blk_idx == 4'd13) state_nxt = ST_LEN_HI;
            end
          end
        end
        ST_LEN_HI: begin
          core_data_valid_o = 1'b1;
          core_data_o       = WORD_W'(bit_len >> WORD_W);
          if (core_ready_i) state_nxt = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          core_data_valid_o = 1'b1;
          core_last_o       = 1'b1;
          core_data_o       = WORD_W'(bit_len);
          if (core_ready_i) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done_i) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lw_sha_host_feeder.md
Name: lw_sha_host_feeder

Overview:
Host-side transmitter for the lightweight SHA/HMAC core interface. It accepts a raw byte-granular message stream and, for HMAC, a 16-word key held in a local register file. It emits the fully padded block stream on the core's start/data_valid/last/ready handshake and streams key words on the core's key_ready handshake. It captures the digest when the core signals done and presents it upstream with a done pulse.

Parameters:
WORD_W, 32, core word width (32 = SHA-224/256 family, 64 = SHA-384/512 family)
OPC_W, 2, core opcode width (4 when WORD_W=64); MSB = HMAC select

Ports:
clk_i  in  1  clock
aresetn_i  in  1  asynchronous active-low reset
go_i  in  1  start request; sampled in IDLE only
opcode_i  in  OPC_W  operation; latched on go_i
abort_i  in  1  cancel; forwarded to core
msg_valid_i  in  1  upstream message word valid
msg_data_i  in  WORD_W  message word, big-endian, MSB byte first
msg_bytes_i  in  log2(WORD_W/8)+1  valid bytes in word, 1..WORD_W/8; meaningful only with msg_last_i
msg_last_i  in  1  final message word
msg_empty_i  in  1  zero-length message; sampled with go_i
msg_ready_o  out  1  message word accepted when msg_valid_i && msg_ready_o
key_we_i  in  1  key register write
key_addr_i  in  4  key word index, 0 = most significant
key_wdata_i  in  WORD_W  key word
core_start_o  out  1  to core start_i
core_opcode_o  out  OPC_W  to core opcode_i
core_abort_o  out  1  to core abort_i
core_data_o  out  WORD_W  to core data_i
core_data_valid_o  out  1  to core data_valid_i
core_last_o  out  1  to core last_i
core_ready_i  in  1  from core ready_o
core_key_o  out  WORD_W  to core key_i
core_key_valid_o  out  1  to core key_valid_i
core_key_ready_i  in  1  from core key_ready_o
core_done_i  in  1  from core done_o
core_hash_i  in  8xWORD_W  from core hash_o
hash_o  out  8xWORD_W  captured digest
done_o  out  1  one-cycle completion pulse
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; hash_o all zero; key file zero; FSM in IDLE. A reset asserted mid-operation returns the block to IDLE immediately. The key file is cleared by reset only.
- FSM states: IDLE, START, KEY, MSG, PAD, LEN_HI, LEN_LO, WAIT.
- IDLE: on go_i, latch opcode_i and msg_empty_i, clear the 64-bit byte counter and the 4-bit word-in-block index, then go to START. go_i is ignored outside IDLE.
- START: drive core_start_o=1 and core_data_valid_o=1 for exactly one cycle, with core_data_o=0 as a dummy. No word is counted. Next state is KEY if opcode MSB=1, otherwise MSG (or PAD if the message is empty).
- KEY: core_key_valid_o=1 and core_key_o = key[k], with k running 0..15. k advances on core_key_valid_o && core_key_ready_i. After k=15 transfers, the byte counter is preset to 16*WORD_W/8 so the key block is included in the length, then go to MSG or PAD.
- MSG: core_data_valid_o = msg_valid_i, core_data_o = msg_data_i, msg_ready_o = core_ready_i. On each transfer, the byte counter adds WORD_W/8, or msg_bytes_i on the last word, and the block index increments (wrapping 15->0).
  - If a last word is partial, replace it with its valid bytes followed by 0x80 and zero fill, and go to PAD with the marker already emitted.
  - If a last word is full, go to PAD with the marker pending.
- PAD: emit a word of 0x80 in the MSB byte followed by zeros if the marker is pending, otherwise emit zeros. Padding continues until the block index = 14, then go to LEN_HI. If the marker word itself lands at index 14 or 15, pad through 15, wrap, and continue into a second block.
- LEN_HI / LEN_LO: the bit length is bytecount*8, forming a 2*WORD_W field.
  - LEN_HI emits the upper word. For WORD_W=32 this is bits 63:32; for WORD_W=64 it is 0.
  - LEN_LO emits the lower word with core_last_o=1, then go to WAIT.
- core_last_o is high only on the LEN_LO word.
- Core handshake: every word from PAD/LEN is held stable while core_data_valid_o && !core_ready_i. It is transferred when both are high.
- WAIT: on core_done_i, hash_o <= core_hash_i and done_o pulses for 1 cycle; go to IDLE.
- Abort: abort_i in any non-IDLE state drives core_abort_o=1 for that cycle and deasserts all valids. hash_o is unchanged, there is no done_o, and the next state is IDLE.
- Simultaneous events: abort_i has priority over a same-cycle transfer or core_done_i. A key_we_i write while busy_o=1 is ignored.

Decomposition:
- Add lw_feeder_pkg holding:
  - the state enum typedef;
  - localparams BLK_WORDS=16, PAD_MARK (0x80 in the MSB byte), BYTES_PER_WORD;
  - a function merge_marker(data, nbytes) returning the padded final word.
- One sub-module, lw_feeder_keyfile: the 16xWORD_W key registers with a write port and a read port indexed by k.

Test Plan:
1. SHA-256, msg_empty_i=1 -> 16 words: word0 0x80000000, words 1..15 0, core_last_o only on word15; digest e3b0c442...b855 is captured and done_o pulses.
2. SHA-256, "abc" as 0x61626300 with bytes=3 and last=1 -> word0 0x61626380, word15 0x00000018; digest ba7816bf...15ad.
3. SHA-256, 56-byte message -> the marker lands at index 14, giving two blocks; block 2 word14=0 and word15=0x000001C0, with last only at the end of block 2.
4. HMAC-SHA-256, key="key" (key[0]=0x6B657900, rest 0), msg "abc" -> 16 key transfers on core_key_ready_i; length word15=0x00000218.
5. core_ready_i toggled 0/1 every cycle during PAD -> core_data_o stable while stalled, no words lost or duplicated, identical digest to scenario 2.
6. abort_i during MSG at word 5 -> core_abort_o pulses, no done_o, hash_o unchanged, busy_o=0 next cycle; a following go_i runs a clean operation.
